// File: rtl/multiexp_pnt_scl_feeder_if.sv
// Point/scalar AXI-stream bundle between the feeder (master) and the multiexp core (slave).
interface multiexp_pnt_scl_feeder_if #(
  parameter int DAT_BITS = 16,
  parameter int CTL_BITS = 8
);
  logic                val;
  logic                rdy;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;
  logic                sop;
  logic                eop;

  modport master (output val, dat, ctl, sop, eop, input rdy);
  modport slave  (input val, dat, ctl, sop, eop, output rdy);
endinterface

// File: rtl/multiexp_pnt_scl_feeder.sv
// Pair RAM replayed as the looping point/scalar stream for the multiexp core,
// with a 2-entry skid buffer so backpressure never loses a read in flight.
module multiexp_pnt_scl_feeder #(
  parameter int FP_BITS  = 0,
  parameter int FE_BITS  = 0,
  parameter int CTL_BITS = 8,
  parameter int NUM_IN   = 4,
  parameter int KEY_BITS = 256
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_wr_val,
  input  logic [$clog2(NUM_IN)-1:0]    i_wr_addr,
  input  logic [FP_BITS+FE_BITS-1:0]   i_wr_dat,
  input  logic                         i_start,
  input  logic                         i_mode,
  multiexp_pnt_scl_feeder_if.master    o_pnt_scl_if,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int DW     = FP_BITS + FE_BITS;
  localparam int ADDR_W = $clog2(NUM_IN);
  localparam int PASS_W = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t              state, state_nxt;
  logic                mode_q;
  logic [ADDR_W-1:0]   rd_addr;
  logic [PASS_W-1:0]   pass_cnt;
  logic [DW-1:0]       mem [NUM_IN];

  logic                rd_pend;
  logic [DW-1:0]       rd_q;
  logic                rd_sop, rd_eop;

  logic [DW-1:0]       fifo_dat [2];
  logic [1:0]          fifo_sop, fifo_eop;
  logic                fifo_rd_ptr, fifo_wr_ptr;
  logic [1:0]          fifo_cnt;

  logic                issue, last_issue;
  logic                out_val, xfer, push, pop, last_xfer;
  logic [2:0]          occupancy;

  // Occupancy counts buffered entries plus the read whose data sits in rd_q.
  assign occupancy = {1'b0, fifo_cnt} + {2'b00, rd_pend};
  assign out_val   = (fifo_cnt != 2'd0) || rd_pend;
  assign xfer      = out_val && o_pnt_scl_if.rdy;
  assign push      = rd_pend && !((fifo_cnt == 2'd0) && xfer);
  assign pop       = xfer && (fifo_cnt != 2'd0);
  assign last_xfer = (state == DRAIN) && xfer && (occupancy == 3'd1);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    last_issue = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_nxt = STREAM;
      end
      STREAM: begin
        if (occupancy <= 3'd1) begin
          issue      = 1'b1;
          last_issue = mode_q ||
                       ((rd_addr == ADDR_W'(NUM_IN - 1)) && (pass_cnt == PASS_W'(KEY_BITS - 1)));
          if (last_issue) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (last_xfer) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_q   <= 1'b0;
      rd_addr  <= '0;
      pass_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_sop   <= 1'b0;
      rd_eop   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done  <= last_xfer;
      rd_pend <= issue;
      if ((state == IDLE) && i_start) begin
        mode_q   <= i_mode;
        rd_addr  <= '0;
        pass_cnt <= '0;
      end else if (issue) begin
        rd_sop <= (rd_addr == '0);
        rd_eop <= mode_q || (rd_addr == ADDR_W'(NUM_IN - 1));
        if (rd_addr == ADDR_W'(NUM_IN - 1)) begin
          rd_addr  <= '0;
          pass_cnt <= pass_cnt + 1'b1;
        end else begin
          rd_addr <= rd_addr + 1'b1;
        end
      end
    end
  end

  // Storage is intentionally left out of reset so loaded pairs survive an abort.
  always_ff @(posedge i_clk) begin
    if (i_wr_val && (state == IDLE)) mem[i_wr_addr] <= i_wr_dat;
    if (issue) rd_q <= mem[rd_addr];
    if (push) begin
      fifo_dat[fifo_wr_ptr] <= rd_q;
      fifo_sop[fifo_wr_ptr] <= rd_sop;
      fifo_eop[fifo_wr_ptr] <= rd_eop;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fifo_rd_ptr <= 1'b0;
      fifo_wr_ptr <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (push) fifo_wr_ptr <= ~fifo_wr_ptr;
      if (pop)  fifo_rd_ptr <= ~fifo_rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // The head comes from the buffer when it holds data, otherwise straight from rd_q.
  always_comb begin
    o_pnt_scl_if.val = out_val;
    o_pnt_scl_if.dat = '0;
    o_pnt_scl_if.sop = 1'b0;
    o_pnt_scl_if.eop = 1'b0;
    o_pnt_scl_if.ctl = '0;
    if (fifo_cnt != 2'd0) begin
      o_pnt_scl_if.dat = fifo_dat[fifo_rd_ptr];
      o_pnt_scl_if.sop = fifo_sop[fifo_rd_ptr];
      o_pnt_scl_if.eop = fifo_eop[fifo_rd_ptr];
      o_pnt_scl_if.ctl = CTL_BITS'(mode_q);
    end else if (rd_pend) begin
      o_pnt_scl_if.dat = rd_q;
      o_pnt_scl_if.sop = rd_sop;
      o_pnt_scl_if.eop = rd_eop;
      o_pnt_scl_if.ctl = CTL_BITS'(mode_q);
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_multiexp_pnt_scl_feeder.sv
// Directed bench for the point/scalar feeder: ordering, latency, backpressure,
// ignored start/write while busy, mid-run reset and write-with-start.
module tb_multiexp_pnt_scl_feeder;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_wr_val = 1'b0;
  logic [1:0]  i_wr_addr = '0;
  logic [15:0] i_wr_dat = '0;
  logic        i_start = 1'b0;
  logic        i_mode = 1'b0;
  logic        o_busy, o_done;

  multiexp_pnt_scl_feeder_if #(.DAT_BITS(16), .CTL_BITS(8)) pnt_scl_if ();

  multiexp_pnt_scl_feeder #(
    .FP_BITS(8), .FE_BITS(8), .CTL_BITS(8), .NUM_IN(4), .KEY_BITS(3)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_wr_val(i_wr_val), .i_wr_addr(i_wr_addr),
    .i_wr_dat(i_wr_dat), .i_start(i_start), .i_mode(i_mode),
    .o_pnt_scl_if(pnt_scl_if), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_mem [4];
  int          first_val_cyc, done_cyc, beats_seen;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic loadPair(input int k);
    @(negedge clk);
    i_wr_val  = 1'b1;
    i_wr_addr = 2'(k);
    i_wr_dat  = {8'(k + 16), 8'(k)};
    exp_mem[k] = {8'(k + 16), 8'(k)};
    @(negedge clk);
    i_wr_val = 1'b0;
  endtask

  task automatic applyStimulus(input bit mode, input bit wr, input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    i_start = 1'b1;
    i_mode  = mode;
    if (wr) begin
      i_wr_val  = 1'b1;
      i_wr_addr = a;
      i_wr_dat  = d;
      exp_mem[a] = d;
    end
    @(negedge clk);
    i_start  = 1'b0;
    i_wr_val = 1'b0;
    checkOutput("busy_t1", 32'(o_busy), 32'd1);
    checkOutput("val_t1", 32'(pnt_scl_if.val), 32'd0);
  endtask

  // Iteration i observes the cycle after the i-th posedge following the start.
  task automatic collectBeats(input bit single, input int rdy_pct, input int stop_after,
                              input int poke_at, input int stall_at);
    int          bc = 0;
    int          stall = 0;
    bit          stalled = 1'b0;
    bit          hold = 1'b0;
    int          idx;
    logic [15:0] pd;
    logic        psop, peop;
    first_val_cyc = -1;
    done_cyc      = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      i_start  = 1'b0;
      i_wr_val = 1'b0;
      if (i == poke_at) begin
        i_start   = 1'b1;
        i_mode    = 1'b1;
        i_wr_val  = 1'b1;
        i_wr_addr = 2'd2;
        i_wr_dat  = 16'hFFFF;
      end
      if (hold) begin
        checkOutput("hold_val", 32'(pnt_scl_if.val), 32'd1);
        checkOutput("hold_dat", 32'(pnt_scl_if.dat), 32'(pd));
        checkOutput("hold_sop", 32'(pnt_scl_if.sop), 32'(psop));
        checkOutput("hold_eop", 32'(pnt_scl_if.eop), 32'(peop));
      end
      if (o_done) begin
        done_cyc = i;
        break;
      end
      if (pnt_scl_if.val && first_val_cyc < 0) first_val_cyc = i;
      if (stall > 0) begin
        pnt_scl_if.rdy = 1'b0;
        stall--;
      end else if (pnt_scl_if.val && bc == stall_at && !stalled) begin
        stalled = 1'b1;
        stall = 9;
        pnt_scl_if.rdy = 1'b0;
      end else begin
        pnt_scl_if.rdy = ($urandom_range(99) < rdy_pct);
      end
      if (pnt_scl_if.val && pnt_scl_if.rdy) begin
        idx = single ? 0 : bc % 4;
        checkOutput($sformatf("dat_b%0d", bc), 32'(pnt_scl_if.dat), 32'(exp_mem[idx]));
        checkOutput($sformatf("sop_b%0d", bc), 32'(pnt_scl_if.sop), 32'(idx == 0));
        checkOutput($sformatf("eop_b%0d", bc), 32'(pnt_scl_if.eop), 32'(single || idx == 3));
        checkOutput($sformatf("ctl_b%0d", bc), 32'(pnt_scl_if.ctl), 32'(single));
        bc++;
      end
      hold = pnt_scl_if.val && !pnt_scl_if.rdy;
      pd   = pnt_scl_if.dat;
      psop = pnt_scl_if.sop;
      peop = pnt_scl_if.eop;
      if (stop_after > 0 && bc == stop_after) break;
    end
    i_start  = 1'b0;
    i_wr_val = 1'b0;
    beats_seen = bc;
    if (stop_after == 0) begin
      if (done_cyc < 0) begin
        checkOutput("done_timeout", 32'd0, 32'd1);
      end else begin
        checkOutput("busy_at_done", 32'(o_busy), 32'd0);
        @(negedge clk);
        checkOutput("done_pulse_end", 32'(o_done), 32'd0);
      end
    end
  endtask

  initial begin
    pnt_scl_if.rdy = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_val", 32'(pnt_scl_if.val), 32'd0);
    checkOutput("rst_dat", 32'(pnt_scl_if.dat), 32'd0);
    checkOutput("rst_ctl", 32'(pnt_scl_if.ctl), 32'd0);
    checkOutput("rst_sop_eop", 32'({pnt_scl_if.sop, pnt_scl_if.eop}), 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_done", 32'(o_done), 32'd0);
    i_rst = 1'b0;
    for (int k = 0; k < 4; k++) loadPair(k);

    $display("[TB] normal run, rdy held high");
    applyStimulus(1'b0, 1'b0, 2'd0, 16'd0);
    collectBeats(1'b0, 100, 0, 0, -1);
    checkOutput("n_first_val", 32'(first_val_cyc), 32'd1);
    checkOutput("n_done_cyc", 32'(done_cyc), 32'd13);
    checkOutput("n_beats", 32'(beats_seen), 32'd12);

    $display("[TB] single-add run");
    applyStimulus(1'b1, 1'b0, 2'd0, 16'd0);
    collectBeats(1'b1, 100, 0, 0, -1);
    checkOutput("s_done_cyc", 32'(done_cyc), 32'd2);
    checkOutput("s_beats", 32'(beats_seen), 32'd1);

    $display("[TB] normal run, random backpressure");
    applyStimulus(1'b0, 1'b0, 2'd0, 16'd0);
    collectBeats(1'b0, 50, 0, 0, -1);
    checkOutput("r_beats", 32'(beats_seen), 32'd12);

    $display("[TB] start and write while busy");
    applyStimulus(1'b0, 1'b0, 2'd0, 16'd0);
    collectBeats(1'b0, 100, 0, 3, -1);
    checkOutput("b_done_cyc", 32'(done_cyc), 32'd13);
    checkOutput("b_beats", 32'(beats_seen), 32'd12);

    $display("[TB] stall across a pass wrap");
    applyStimulus(1'b0, 1'b0, 2'd0, 16'd0);
    collectBeats(1'b0, 100, 0, 0, 4);
    checkOutput("w_beats", 32'(beats_seen), 32'd12);

    $display("[TB] reset after five beats");
    applyStimulus(1'b0, 1'b0, 2'd0, 16'd0);
    collectBeats(1'b0, 100, 5, 0, -1);
    checkOutput("a_beats", 32'(beats_seen), 32'd5);
    @(negedge clk);
    pnt_scl_if.rdy = 1'b0;
    i_rst = 1'b1;
    @(negedge clk);
    checkOutput("a_val", 32'(pnt_scl_if.val), 32'd0);
    checkOutput("a_busy", 32'(o_busy), 32'd0);
    checkOutput("a_done", 32'(o_done), 32'd0);
    checkOutput("a_dat", 32'(pnt_scl_if.dat), 32'd0);
    i_rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0, 16'd0);
    collectBeats(1'b0, 100, 0, 0, -1);
    checkOutput("a2_done_cyc", 32'(done_cyc), 32'd13);
    checkOutput("a2_beats", 32'(beats_seen), 32'd12);

    $display("[TB] write together with start");
    applyStimulus(1'b0, 1'b1, 2'd0, 16'hA55A);
    collectBeats(1'b0, 100, 0, 0, -1);
    checkOutput("ws_done_cyc", 32'(done_cyc), 32'd13);
    checkOutput("ws_beats", 32'(beats_seen), 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiexp_pnt_scl_feeder.md
# multiexp_pnt_scl_feeder

Source side of the multiexp point/scalar stream. Holds NUM_IN {point, scalar} pairs in on-chip RAM, loaded through a simple write port. On a start command it replays them as the looping AXI-stream that the multiexp core consumes:
- normal mode: KEY_BITS full passes, indices 0..NUM_IN-1;
- single-add mode: one beat.

It sits between the host/DMA load path and the multiexp core's point/scalar sink. It supports arbitrary backpressure.

## Interface
Parameters:
- FP_BITS, 0 (must override): width of one point (FP_TYPE).
- FE_BITS, 0 (must override): width of one scalar (FE_TYPE).
- CTL_BITS, 8: stream ctl width.
- NUM_IN, 4: pairs in memory, ≥2.
- KEY_BITS, 256: passes per normal-mode run, ≥1.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_wr_val  in  1  write strobe to pair RAM.
- i_wr_addr  in  $clog2(NUM_IN)  write index.
- i_wr_dat  in  FP_BITS+FE_BITS  {point, scalar}; scalar in LSBs.
- i_start  in  1  one-cycle start pulse.
- i_mode  in  1  sampled with i_start: 0 = normal, 1 = single-add.
- o_pnt_scl_if  source  dat FP_BITS+FE_BITS, ctl CTL_BITS  if_axi_stream carrying val, rdy, dat, ctl, sop, eop.
- o_busy  out  1  high from accepted start until the final beat is accepted.
- o_done  out  1  one-cycle pulse on the cycle after the final beat is accepted.

## Operation
- RAM: NUM_IN × (FP_BITS+FE_BITS), one synchronous write port and one synchronous read port, read latency 1.
  - A write is accepted only when o_busy=0. Writes during busy are dropped.
  - Contents are not cleared by reset.
- States:
  - IDLE: o_busy=0. i_start=1 latches the mode, clears rd_addr and pass_cnt, and moves to STREAM.
  - STREAM:
    - issue reads while the output buffer has space;
    - rd_addr increments per read and wraps NUM_IN-1→0;
    - pass_cnt increments on each wrap.
    - All beats issued → DRAIN.
  - DRAIN: wait until the buffer is empty and the last beat is accepted, pulse o_done, then go to IDLE.
- Beats issued:
  - normal mode: NUM_IN×KEY_BITS beats in index order 0,1,…,NUM_IN-1,0,… ;
  - single-add mode: exactly 1 beat, index 0.
- Output buffer:
  - 2-entry skid FIFO, so a read in flight is never lost when rdy drops.
  - A read is issued only if the number of occupied entries plus reads in flight is ≤ 1.
- Beat fields:
  - dat = RAM[index].
  - ctl[0] = latched mode; ctl[CTL_BITS-1:1] = 0.
  - sop = 1 when index==0.
  - eop = 1 when index==NUM_IN-1, or always in single-add mode.
- i_start while o_busy=1 is ignored. i_mode is sampled only with an accepted start.

## Timing
- Reset values:
  - o_pnt_scl_if.val=0, dat=0, ctl=0, sop=0, eop=0;
  - o_busy=0, o_done=0;
  - state IDLE, buffer empty, all counters 0.
- Reset mid-run aborts immediately, with reset values on the next cycle. Any in-flight read is discarded.
- Latency:
  - start at cycle T → o_busy=1 at T+1, first val=1 at T+2.
  - With rdy held high, one beat per cycle, no bubbles, including across pass wraps.
- Handshake:
  - A beat transfers when val&&rdy.
  - While val=1 and rdy=0, dat, ctl, sop and eop hold stable.
  - val never drops without a transfer.
  - The feeder must not depend on rdy being combinationally related to val; rdy may be registered by the sink.
- Completion:
  - The final beat transfers at cycle F.
  - At F+1: o_busy=0, o_done=1.
  - At F+2: o_done=0.
  - A new start is accepted from F+1.
- A simultaneous i_wr_val and i_start in IDLE: the write is performed and start is accepted. The read of that address is issued no earlier than T+1, so it sees the new data.

## Test plan
- Load NUM_IN=4, KEY_BITS=3, dat[k]={pnt=k+16, scl=k}; start mode 0, rdy=1 → 12 beats at T+2..T+13; scl sequence 0,1,2,3 ×3; sop on idx 0, eop on idx 3; o_done at T+14.
- Same load, mode 1 → exactly one beat {16,0} with ctl[0]=1, sop=eop=1; o_done the cycle after acceptance.
- Normal run with rdy random 50% → same 12-beat sequence, no loss or duplication; dat stable on every rdy=0 cycle with val=1.
- Start during busy, and write addr 2 during busy → ignored: beat count stays 12 and RAM[2] is unchanged on the next run.
- Assert i_rst after 5 accepted beats → the next cycle shows val=0 and busy=0. A fresh start then replays from idx 0 with the original RAM contents.
- rdy=0 for 10 cycles at a pass wrap (idx 3→0) → no more than 2 beats buffered; order preserved on resume.
